// File: rtl/ntsc_tg_ctl.sv
// ntsc_tg_ctl -- NTSC 4fsc progressive (240p) timing sequencer.
//
// Produces the per-sample control set for the composite modulator and the
// pixel requests for the upstream pixel generator.
//
// Ports
//   CK_i      clock (single domain)
//   AR_i      asynchronous reset, active-high
//   CK_EE_i   clock enable; all state advances only when 1
//   RUN_i     1 = run timing, 0 = hold idle
//   DE_o      pixel request (undelayed)
//   PIX_X_o   request column, 0 when DE_o=0
//   PIX_Y_o   request row, 0 when DE_o=0
//   FRAME_o   one enabled-cycle pulse at h=0, v=0 (undelayed)
//   XSYNC_o   0 = sync tip (delayed by PIPE_DLY)
//   BLANK_o   1 = blanking (delayed by PIPE_DLY)
//   BURST_o   1 = burst gate (delayed by PIPE_DLY)
//   XR_o      0 = modulator phase/output reset (delayed by PIPE_DLY)
//   HCNT_o    raw horizontal counter
//   VCNT_o    raw vertical counter
module ntsc_tg_ctl #(
  parameter int H_TOTAL     = 910,
  parameter int V_TOTAL     = 262,
  parameter int ACT_H_START = 160,
  parameter int ACT_H_PIX   = 720,
  parameter int ACT_V_START = 22,
  parameter int ACT_V_LINES = 240,
  parameter int PIPE_DLY    = 2
) (
  input  logic       CK_i,
  input  logic       AR_i,
  input  logic       CK_EE_i,
  input  logic       RUN_i,
  output logic       DE_o,
  output logic [9:0] PIX_X_o,
  output logic [8:0] PIX_Y_o,
  output logic       FRAME_o,
  output logic       XSYNC_o,
  output logic       BLANK_o,
  output logic       BURST_o,
  output logic       XR_o,
  output logic [9:0] HCNT_o,
  output logic [8:0] VCNT_o
);

  localparam logic [9:0] H_LAST    = 10'(H_TOTAL - 1);
  localparam logic [8:0] V_LAST    = 9'(V_TOTAL - 1);
  localparam logic [9:0] AH_FIRST  = 10'(ACT_H_START);
  localparam logic [9:0] AH_LAST   = 10'(ACT_H_START + ACT_H_PIX - 1);
  localparam logic [8:0] AV_FIRST  = 9'(ACT_V_START);
  localparam logic [8:0] AV_END    = 9'(ACT_V_START + ACT_V_LINES);
  // {XSYNC, BLANK, BURST, XR} while idle or in reset
  localparam logic [3:0] IDLE_WORD = 4'b1100;

  typedef enum logic [2:0] {
    EQ_PRE,
    VSYNC,
    EQ_POST,
    VBLANK,
    ACTIVE
  } line_e;

  // Line-type transition, evaluated with the line number being entered.
  function automatic line_e line_next(input line_e cur, input logic [8:0] v);
    line_e nxt;
    nxt = cur;
    case (cur)
      EQ_PRE:  if (v == 9'd3) nxt = VSYNC;
      VSYNC:   if (v == 9'd6) nxt = EQ_POST;
      EQ_POST: if (v == 9'd9) nxt = (v == AV_FIRST) ? ACTIVE : VBLANK;
      VBLANK: begin
        if (v == 9'd0)          nxt = EQ_PRE;
        else if (v == AV_FIRST) nxt = ACTIVE;
      end
      ACTIVE: begin
        if (v == 9'd0)        nxt = EQ_PRE;
        else if (v == AV_END) nxt = VBLANK;
      end
      default: nxt = EQ_PRE;
    endcase
    return nxt;
  endfunction

  logic       run_q, run_d;
  logic [9:0] h_q, h_d;
  logic [8:0] v_q, v_d;
  line_e      line_q, line_d;
  logic       de_q, de_d;
  logic       frame_q, frame_d;
  logic [9:0] pix_x_q, pix_x_d;
  logic [8:0] pix_y_q, pix_y_d;
  logic [3:0] ctl_p0_q, ctl_p0_d;
  logic       sync_low, burst_on, act_h;
  logic [3:0] ctl_out;

  always_comb begin
    run_d  = run_q;
    h_d    = h_q;
    v_d    = v_q;
    line_d = line_q;
    if (!RUN_i) begin
      run_d  = 1'b0;
      h_d    = '0;
      v_d    = '0;
      line_d = EQ_PRE;
    end else if (!run_q) begin
      // first enabled edge after idle restarts the frame at (0,0)
      run_d  = 1'b1;
      h_d    = '0;
      v_d    = '0;
      line_d = EQ_PRE;
    end else if (h_q == H_LAST) begin
      h_d    = '0;
      v_d    = (v_q == V_LAST) ? 9'd0 : v_q + 9'd1;
      line_d = line_next(line_q, v_d);
    end else begin
      h_d    = h_q + 10'd1;
    end

    case (line_d)
      EQ_PRE, EQ_POST: sync_low = (h_d <= 10'd32) ||
                                  ((h_d >= 10'd455) && (h_d <= 10'd487));
      VSYNC:           sync_low = (h_d <= 10'd387) ||
                                  ((h_d >= 10'd455) && (h_d <= 10'd842));
      default:         sync_low = (h_d <= 10'd66);
    endcase

    burst_on = ((line_d == VBLANK) || (line_d == ACTIVE)) &&
               (h_d >= 10'd76) && (h_d <= 10'd111);
    act_h    = (h_d >= AH_FIRST) && (h_d <= AH_LAST);
    de_d     = RUN_i && (line_d == ACTIVE) && act_h;
    frame_d  = RUN_i && (h_d == 10'd0) && (v_d == 9'd0);
    pix_x_d  = de_d ? (h_d - AH_FIRST) : 10'd0;
    pix_y_d  = de_d ? (v_d - AV_FIRST) : 9'd0;
    ctl_p0_d = RUN_i ? {~sync_low, ~de_d, burst_on, 1'b1} : IDLE_WORD;
  end

  // Stage p0: counters, requests and the raw control word
  always_ff @(posedge CK_i or posedge AR_i) begin
    if (AR_i) begin
      run_q    <= 1'b0;
      h_q      <= '0;
      v_q      <= '0;
      line_q   <= EQ_PRE;
      de_q     <= 1'b0;
      frame_q  <= 1'b0;
      pix_x_q  <= '0;
      pix_y_q  <= '0;
      ctl_p0_q <= IDLE_WORD;
    end else if (CK_EE_i) begin
      run_q    <= run_d;
      h_q      <= h_d;
      v_q      <= v_d;
      line_q   <= line_d;
      de_q     <= de_d;
      frame_q  <= frame_d;
      pix_x_q  <= pix_x_d;
      pix_y_q  <= pix_y_d;
      ctl_p0_q <= ctl_p0_d;
    end
  end

  // Stages p1..pPIPE_DLY: control word aligned with the upstream pixel latency
  generate
    if (PIPE_DLY == 0) begin : g_nodly
      assign ctl_out = ctl_p0_q;
    end else begin : g_dly
      logic [3:0] dly_q [PIPE_DLY];
      logic [3:0] dly_d [PIPE_DLY];

      always_comb begin
        dly_d[0] = ctl_p0_q;
        for (int i = 1; i < PIPE_DLY; i++) dly_d[i] = dly_q[i-1];
      end

      always_ff @(posedge CK_i or posedge AR_i) begin
        if (AR_i) begin
          for (int i = 0; i < PIPE_DLY; i++) dly_q[i] <= IDLE_WORD;
        end else if (CK_EE_i) begin
          for (int i = 0; i < PIPE_DLY; i++) dly_q[i] <= dly_d[i];
        end
      end

      assign ctl_out = dly_q[PIPE_DLY-1];
    end
  endgenerate

  assign DE_o    = de_q;
  assign FRAME_o = frame_q;
  assign PIX_X_o = pix_x_q;
  assign PIX_Y_o = pix_y_q;
  assign HCNT_o  = h_q;
  assign VCNT_o  = v_q;
  assign XSYNC_o = ctl_out[3];
  assign BLANK_o = ctl_out[2];
  assign BURST_o = ctl_out[1];
  assign XR_o    = ctl_out[0];

endmodule

// File: tb/tb_ntsc_tg_ctl.sv
// Self-checking bench for ntsc_tg_ctl with a reduced frame height so that a
// full frame wrap fits in a short run. Line width and sync/burst/active
// geometry stay at their native values.
module tb_ntsc_tg_ctl;

  localparam int HT  = 910;
  localparam int VT  = 30;
  localparam int AHS = 160;
  localparam int AHP = 720;
  localparam int AVS = 22;
  localparam int AVL = 6;
  localparam int PD  = 2;

  localparam int K_EQ  = 0;
  localparam int K_VS  = 1;
  localparam int K_VB  = 2;
  localparam int K_ACT = 3;

  localparam int CLK_LIMIT = 90000;

  logic       CK_i = 1'b0;
  logic       AR_i, CK_EE_i, RUN_i;
  logic       DE_o, FRAME_o, XSYNC_o, BLANK_o, BURST_o, XR_o;
  logic [9:0] PIX_X_o, HCNT_o;
  logic [8:0] PIX_Y_o, VCNT_o;

  ntsc_tg_ctl #(
    .H_TOTAL(HT), .V_TOTAL(VT), .ACT_H_START(AHS), .ACT_H_PIX(AHP),
    .ACT_V_START(AVS), .ACT_V_LINES(AVL), .PIPE_DLY(PD)
  ) dut (
    .CK_i(CK_i), .AR_i(AR_i), .CK_EE_i(CK_EE_i), .RUN_i(RUN_i),
    .DE_o(DE_o), .PIX_X_o(PIX_X_o), .PIX_Y_o(PIX_Y_o), .FRAME_o(FRAME_o),
    .XSYNC_o(XSYNC_o), .BLANK_o(BLANK_o), .BURST_o(BURST_o), .XR_o(XR_o),
    .HCNT_o(HCNT_o), .VCNT_o(VCNT_o)
  );

  always #5 CK_i = ~CK_i;

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference model: sample position plus the control words still in flight.
  int         m_run, mh, mv, m_de, m_fr, m_px, m_py;
  logic [3:0] q[$];

  function automatic int kind(input int v);
    if (v < 3)                     return K_EQ;
    if (v < 6)                     return K_VS;
    if (v < 9)                     return K_EQ;
    if (v >= AVS && v < AVS + AVL) return K_ACT;
    return K_VB;
  endfunction

  task automatic model_reset();
    m_run = 0; mh = 0; mv = 0; m_de = 0; m_fr = 0; m_px = 0; m_py = 0;
    q.delete();
    repeat (PD + 1) q.push_back(4'b1100);
  endtask

  task automatic model_step(input logic run);
    int k;
    logic xs, bu;
    logic [3:0] w;
    if (!run) begin
      m_run = 0; mh = 0; mv = 0; m_de = 0; m_fr = 0; m_px = 0; m_py = 0;
      w = 4'b1100;
    end else begin
      if (m_run == 0) begin
        m_run = 1; mh = 0; mv = 0;
      end else begin
        mh++;
        if (mh == HT) begin
          mh = 0;
          mv = (mv + 1) % VT;
        end
      end
      k = kind(mv);
      if (k == K_EQ)      xs = !((mh <= 32) || (mh >= 455 && mh <= 487));
      else if (k == K_VS) xs = !((mh <= 387) || (mh >= 455 && mh <= 842));
      else                xs = !(mh <= 66);
      bu   = (k == K_VB || k == K_ACT) && mh >= 76 && mh <= 111;
      m_de = (k == K_ACT && mh >= AHS && mh < AHS + AHP) ? 1 : 0;
      m_px = m_de ? mh - AHS : 0;
      m_py = m_de ? mv - AVS : 0;
      m_fr = (mh == 0 && mv == 0) ? 1 : 0;
      w = {xs, (m_de == 0), bu, 1'b1};
    end
    q.push_back(w);
    void'(q.pop_front());
  endtask

  function automatic logic [63:0] model_word();
    return {20'd0, 1'(m_de), 1'(m_fr), q[0], 10'(m_px), 9'(m_py), 10'(mh), 9'(mv)};
  endfunction

  function automatic logic [63:0] dut_word();
    return {20'd0, DE_o, FRAME_o, XSYNC_o, BLANK_o, BURST_o, XR_o,
            PIX_X_o, PIX_Y_o, HCNT_o, VCNT_o};
  endfunction

  int clk_cnt = 0;
  bit trk = 0;
  int frames_seen = 0;
  int since = 0;
  int de_cnt = 0;

  task automatic cycle(input logic ee, input logic run);
    CK_EE_i = ee;
    RUN_i   = run;
    @(posedge CK_i);
    #1;
    clk_cnt++;
    if (ee && !AR_i) model_step(run);
    check("outs", dut_word(), model_word());
    if (ee && trk) begin
      since++;
      de_cnt += int'(DE_o);
      if (FRAME_o) begin
        if (frames_seen > 0) begin
          check("frame_period", 64'(since), 64'(HT * VT));
          check("de_per_frame", 64'(de_cnt), 64'(AHP * AVL));
        end
        frames_seen++;
        since  = 0;
        de_cnt = 0;
      end
    end
  endtask

  initial begin
    logic ee;
    AR_i = 1'b1; CK_EE_i = 1'b1; RUN_i = 1'b1;
    model_reset();

    // Reset holds its values while clocks run
    repeat (3) cycle(1'b1, 1'b1);
    check("rst_xsync", 64'(XSYNC_o), 64'd1);
    check("rst_xr", 64'(XR_o), 64'd0);
    AR_i = 1'b0;

    // First run edge and XR latency
    trk = 1;
    cycle(1'b1, 1'b1);
    check("first_frame", 64'(FRAME_o), 64'd1);
    check("first_hv", {HCNT_o, VCNT_o}, 64'd0);
    cycle(1'b1, 1'b1);
    check("xr_lag1", 64'(XR_o), 64'd0);
    cycle(1'b1, 1'b1);
    check("xr_lag2", 64'(XR_o), 64'd1);

    // Random enables across a full frame wrap, then run to v=24,h=400
    while (!(frames_seen >= 2 && mv == 24 && mh == 400) && clk_cnt < CLK_LIMIT) begin
      ee = (frames_seen >= 2) ? 1'b1 : ($urandom_range(0, 3) != 0);
      cycle(ee, 1'b1);
    end
    trk = 0;
    check("reached_drop", 64'(frames_seen >= 2 && mv == 24 && mh == 400), 64'd1);
    check("pre_drop_de", 64'(DE_o), 64'd1);
    check("pre_drop_pix", {PIX_X_o, PIX_Y_o}, {10'd240, 9'd2});

    // RUN drop in an active line
    cycle(1'b1, 1'b0);
    check("drop_hcnt", 64'(HCNT_o), 64'd0);
    check("drop_de", 64'(DE_o), 64'd0);
    check("drop_inflight_xr", 64'(XR_o), 64'd1);
    cycle(1'b1, 1'b0);
    cycle(1'b1, 1'b0);
    check("drop_idle_word", {XSYNC_o, BLANK_o, BURST_o, XR_o}, 64'b1100);
    cycle(1'b1, 1'b1);
    check("restart_frame", {FRAME_o, HCNT_o, VCNT_o}, {1'b1, 19'd0});

    // Random RUN segments, some with an alternating enable
    for (int s = 0; s < 12; s++) begin
      logic run;
      bit   alt;
      int   len;
      run = (s % 2 == 0) ? 1'b0 : 1'b1;
      alt = ($urandom_range(0, 1) == 1);
      len = $urandom_range(1, 1200);
      for (int i = 0; i < len; i++) begin
        ee = alt ? ((i % 2) == 0) : ($urandom_range(0, 3) != 0);
        cycle(ee, run);
      end
    end

    // Asynchronous reset mid-line with the enable low
    repeat (300) cycle(1'b1, 1'b1);
    CK_EE_i = 1'b0;
    #3;
    AR_i = 1'b1;
    #1;
    model_reset();
    check("async_rst", dut_word(), model_word());
    cycle(1'b1, 1'b1);
    AR_i = 1'b0;
    repeat (200) cycle(1'b1, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
